// File: rtl/neuron_argmax_collector.sv
// ---------------------------------------------------------------------------
// neuron_argmax_collector
//
// Purpose:
//   This is the downstream stage of the neuron output layer. When the layer
//   pulses `finish`, the block captures the packed neuron outputs. It then
//   scans them one element per clock for the largest signed value. Ties go to
//   the lowest index. Each {index, max} result is queued in a small FIFO and
//   offered to the result consumer on a valid/ready port.
//
// Optional feature (macro ARGMAX_RELU_EN):
//   When defined, every element is clamped to 0 if it is negative, before it
//   is compared. This gives res_max >= 0, and an all-negative vector yields
//   idx=0, max=0. When undefined, the comparison is raw signed and res_max
//   may be negative.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   finish     in   one-cycle pulse: out_vec is valid this cycle
//   out_vec    in   N_NEURONS*DATA_W packed outputs, neuron i at [i*DATA_W +: DATA_W]
//   res_valid  out  FIFO non-empty; res_idx/res_max show the head entry
//   res_ready  in   consumer accepts the head when res_valid && res_ready
//   res_idx    out  index of the winning neuron (head entry)
//   res_max    out  value of the winning neuron (head entry)
//   busy       out  high while in SCAN or WRITE
//   overflow   out  sticky: a finish pulse arrived while busy and was dropped
//   dbg_state  out  current FSM state (0 IDLE, 1 SCAN, 2 WRITE)
//
// Handshake: an entry transfers on a rising edge where res_valid && res_ready.
//   While res_valid is high and res_ready is low, the head entry is held
//   stable. res_valid never drops without a transfer, except on reset.
// ---------------------------------------------------------------------------
module neuron_argmax_collector #(
  parameter int N_NEURONS  = 8,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          finish,
  input  logic [N_NEURONS*DATA_W-1:0]   out_vec,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [IDX_W-1:0]              res_idx,
  output logic [DATA_W-1:0]             res_max,
  output logic                          busy,
  output logic                          overflow,
  output logic [1:0]                    dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                        r_state;
  logic [N_NEURONS*DATA_W-1:0]   r_vec;
  logic [IDX_W-1:0]              r_cnt;
  logic [IDX_W-1:0]              r_idx;
  logic [DATA_W-1:0]             r_max;
  logic                          r_overflow;

  logic [IDX_W-1:0]              r_mem_idx [FIFO_DEPTH];
  logic [DATA_W-1:0]             r_mem_max [FIFO_DEPTH];
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [CNT_W-1:0]              r_count;

  logic [N_NEURONS*DATA_W-1:0]   w_vec_in;
  logic [DATA_W-1:0]             w_elem;
  logic                          w_full;
  logic                          w_pop;
  logic                          w_push;

  // Clamp negatives to zero when ReLU is enabled; identity otherwise.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
`ifdef ARGMAX_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // The clamp is applied once, at capture. The scan then only ever sees
  // values that are already clamped.
  always_comb begin
    w_vec_in = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      w_vec_in[i*DATA_W +: DATA_W] = relu(out_vec[i*DATA_W +: DATA_W]);
    end
  end

  assign w_elem = r_vec[int'(r_cnt)*DATA_W +: DATA_W];

  assign res_valid = (r_count != '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = res_valid && res_ready;
  // A full FIFO can still accept the result on an edge where it also pops.
  assign w_push    = (r_state == ST_WRITE) && (!w_full || w_pop);

  assign busy      = (r_state != ST_IDLE);
  assign overflow  = r_overflow;
  assign dbg_state = r_state;
  assign res_idx   = r_mem_idx[r_rd_ptr];
  assign res_max   = r_mem_max[r_rd_ptr];

  // Control FSM and scan datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_vec      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_max      <= '0;
      r_overflow <= 1'b0;
    end else begin
      // A finish pulse that arrives while busy is dropped. The scan that is
      // already in flight carries on unaffected.
      if (finish && (r_state != ST_IDLE)) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (finish) begin
            r_vec   <= w_vec_in;
            r_max   <= w_vec_in[DATA_W-1:0];
            r_idx   <= '0;
            r_cnt   <= IDX_W'(1);
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // A strict greater-than keeps the earliest index on ties.
          if ($signed(w_elem) > $signed(r_max)) begin
            r_max <= w_elem;
            r_idx <= r_cnt;
          end
          r_cnt <= r_cnt + IDX_W'(1);
          if (r_cnt == IDX_W'(N_NEURONS - 1)) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_push) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result FIFO. The head entry is driven straight from storage, with no
  // write-to-read bypass, so a pushed entry first shows up after its edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_idx[i] <= '0;
        r_mem_max[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_idx[r_wr_ptr] <= r_idx;
        r_mem_max[r_wr_ptr] <= r_max;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_argmax_collector.sv
// ---------------------------------------------------------------------------
// tb_neuron_argmax_collector
//
// Purpose:
//   Directed bench for neuron_argmax_collector. It covers capture and scan
//   latency, tie-break, all-negative vectors, a finish pulse dropped while
//   busy, a full FIFO with a stalled WRITE, push and pop on the same edge,
//   and reset while a scan is in progress. Each expected result is written
//   by hand and kept in exp_q in the order the results should leave the FIFO.
//
// Timing: inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_neuron_argmax_collector;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic          finish;
  logic [N*DW-1:0] out_vec;
  logic          res_valid;
  logic          res_ready;
  logic [IW-1:0] res_idx;
  logic [DW-1:0] res_max;
  logic          busy;
  logic          overflow;
  logic [1:0]    dbg_state;

  logic [IW+DW-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  neuron_argmax_collector #(
    .N_NEURONS (N),
    .DATA_W    (DW),
    .IDX_W     (IW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .finish    (finish),
    .out_vec   (out_vec),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_idx   (res_idx),
    .res_max   (res_max),
    .busy      (busy),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every element is 1, except element k, which holds v.
  function automatic logic [N*DW-1:0] vec_peak(input int k, input logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = (i == k) ? v : 8'd1;
    return r;
  endfunction

  // driver tasks (called at a falling edge, and return at a falling edge)
  task automatic send(input logic [N*DW-1:0] v);
    finish  = 1'b1;
    out_vec = v;
    @(negedge clk);
    finish  = 1'b0;
    out_vec = {N{8'h7F}};  // a late change that must not be resampled
  endtask

  task automatic pop1();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!res_valid && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_timeout"}, res_valid, 1);
  endtask

  // Compare the head entry with the oldest expected result
  task automatic chk_head(input string tag);
    logic [IW+DW-1:0] e;
    e = (exp_q.size() != 0) ? exp_q[0] : '1;
    chk({tag, "_idx"}, res_idx, e[IW+DW-1:DW]);
    chk({tag, "_max"}, res_max, e[DW-1:0]);
  endtask

  initial begin
    int seen;
    rst = 1'b0; finish = 1'b0; out_vec = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_max", res_max, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: tie between idx 2 and idx 4 at 17; the lower index must win
    send({8'd2, 8'h80, 8'd0, 8'd17, 8'd9, 8'd17, 8'hFD, 8'd5});
    exp_q.push_back({3'd2, 8'd17});
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_busy_%0d", i), busy, 1);
      chk($sformatf("t1_nvalid_%0d", i), res_valid, 0);
      @(negedge clk);
    end
    chk("t1_busy_done", busy, 0);
    chk("t1_valid", res_valid, 1);
    chk_head("t1");
    pop1();
    void'(exp_q.pop_front());
    chk("t1_empty", res_valid, 0);

    // 2: all -1
    send({N{8'hFF}});
`ifdef ARGMAX_RELU_EN
    exp_q.push_back({3'd0, 8'd0});
`else
    exp_q.push_back({3'd0, 8'hFF});
`endif
    wait_valid("t2");
    chk_head("t2");
    pop1();
    void'(exp_q.pop_front());

    // 3: a second finish 3 cycles after an accepted one is dropped
    send(vec_peak(5, 8'd50));
    exp_q.push_back({3'd5, 8'd50});
    repeat (2) @(negedge clk);
    chk("t3_ovf_before", overflow, 0);
    send(vec_peak(1, 8'd100));
    chk("t3_ovf", overflow, 1);
    wait_valid("t3");
    chk_head("t3");
    pop1();
    void'(exp_q.pop_front());
    seen = 0;
    repeat (12) begin
      if (res_valid) seen++;
      @(negedge clk);
    end
    chk("t3_no_extra", seen, 0);
    chk("t3_ovf_sticky", overflow, 1);

    // 4: consumer stalled, five vectors spaced 9 cycles apart
    for (int k = 0; k < 5; k++) begin
      send(vec_peak(k, 8'(10 + k)));
      exp_q.push_back({3'(k), 8'(10 + k)});
      repeat (8) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("t4_busy_stall", busy, 1);
    chk("t4_state_write", dbg_state, 2);
    chk("t4_valid", res_valid, 1);
    chk_head("t4_head0");

    // 5: full FIFO with WRITE pending; one pop must also push on that edge
    pop1();
    void'(exp_q.pop_front());
    chk("t5_busy_free", busy, 0);
    chk("t5_valid", res_valid, 1);
    chk_head("t5_head1");
    send(vec_peak(5, 8'd15));
    exp_q.push_back({3'd5, 8'd15});
    repeat (10) @(negedge clk);
    chk("t5_still_full", busy, 1);
    chk("t5_state_write", dbg_state, 2);

    // drain in order: idx 1..5
    res_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      if (res_valid) begin
        chk_head($sformatf("drain_%0d", i));
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("drain_all", exp_q.size(), 0);
    chk("drain_empty", res_valid, 0);
    chk("drain_idle", busy, 0);

    // 6: reset while a scan is in progress, with two entries queued
    send(vec_peak(3, 8'd33));
    repeat (8) @(negedge clk);
    send(vec_peak(6, 8'd66));
    repeat (8) @(negedge clk);
    send(vec_peak(2, 8'd22));
    repeat (3) @(negedge clk);
    chk("t6_valid_pre", res_valid, 1);
    chk("t6_scan", dbg_state, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", res_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    res_ready = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    chk("t6_no_stale", seen, 0);
    chk("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
